hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage MIPS core. It generates per-stage stall and flush controls from load-use dependences, a multi-cycle MDU (divider) handshake, and IF/MEM stall requests. It also produces the exception/ERET redirect PC. A registered MDU FSM issues a one-cycle start pulse. A pending-redirect register holds the redirect PC until fetch can accept it. A saturating counter tracks load-use stall cycles.

---
 rtl/hazard_ctrl_if.sv | 62 ++++++
 rtl/hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: dependence, MDU handshake, cache
// stall requests and exception info in; stall/flush/redirect controls out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  // ID-stage operands
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  // Loads in flight
  logic             ex_rmem;
  logic [4:0]       ex_wreg;
  logic             mem_rmem;
  logic [4:0]       mem_wreg;
  // Divider handshake
  logic             ex_mdu_op;
  logic             mdu_ready;
  // Cache stall requests
  logic             stallreq_from_if;
  logic             stallreq_from_mem;
  // Exception info from MEM
  logic [31:0]      mem_excepttype;
  logic [31:0]      mem_cp0_epc;
  // Controls back to the pipeline
  logic             if_stall;
  logic             id_stall;
  logic             ex_stall;
  logic             mem_stall;
  logic             if_flush;
  logic             id_flush;
  logic             ex_flush;
  logic             mem_flush;
  logic             wb_flush;
  logic             mdu_start;
  logic             mdu_cancel;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] lu_stall_cnt;

  // Pipeline side: drives status, consumes controls
  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output ex_rmem, ex_wreg, mem_rmem, mem_wreg,
    output ex_mdu_op, mdu_ready, stallreq_from_if, stallreq_from_mem,
    output mem_excepttype, mem_cp0_epc,
    input  if_stall, id_stall, ex_stall, mem_stall,
    input  if_flush, id_flush, ex_flush, mem_flush, wb_flush,
    input  mdu_start, mdu_cancel, redirect_valid, redirect_pc, lu_stall_cnt
  );

  // Controller side
  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  ex_rmem, ex_wreg, mem_rmem, mem_wreg,
    input  ex_mdu_op, mdu_ready, stallreq_from_if, stallreq_from_mem,
    input  mem_excepttype, mem_cp0_epc,
    output if_stall, id_stall, ex_stall, mem_stall,
    output if_flush, id_flush, ex_flush, mem_flush, wb_flush,
    output mdu_start, mdu_cancel, redirect_valid, redirect_pc, lu_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use and divider
// stalls, exception/ERET flushes, a pending redirect held while fetch is
// busy, and a saturating count of load-use stall cycles.
module hazard_ctrl #(
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380,
  parameter logic [31:0] ERET_TYPE      = 32'h0000000E,
  parameter int          LOAD_USE_DEPTH = 1,
  parameter int          CNT_W          = 16
) (
  input  logic         clk,
  input  logic         resetn,
  hazard_ctrl_if.slave bus
);

  localparam logic CHECK_MEM_LOAD = (LOAD_USE_DEPTH == 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mdu_state_e;

  mdu_state_e       state_q, state_d;
  logic             mdu_start_q, mdu_start_d;
  logic             pend_q, pend_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             lwstall_s;
  logic             flush_except_s;
  logic [31:0]      exc_pc_s;
  logic             mdu_stall_s;
  logic             mdu_cancel_s;
  logic             ex_stall_s;
  logic             ifid_stall_s;
  logic             ex_flush_s;
  logic             wb_flush_s;
  logic             redirect_valid_s;
  logic [31:0]      redirect_pc_s;

  // True when a nonzero register r is actually read by the ID instruction
  function automatic logic reg_hit(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic use_rs,
                                   input logic use_rt);
    return (r != 5'd0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  // Decode load-use dependence, exception presence and the redirect target
  always_comb begin
    lwstall_s      = 1'b0;
    flush_except_s = 1'b0;
    exc_pc_s       = EXC_VECTOR;
    if (bus.ex_rmem && reg_hit(bus.ex_wreg, bus.id_rs, bus.id_rt,
                               bus.id_uses_rs, bus.id_uses_rt)) begin
      lwstall_s = 1'b1;
    end else if (CHECK_MEM_LOAD && bus.mem_rmem &&
                 reg_hit(bus.mem_wreg, bus.id_rs, bus.id_rt,
                         bus.id_uses_rs, bus.id_uses_rt)) begin
      lwstall_s = 1'b1;
    end else begin
      lwstall_s = 1'b0;
    end
    flush_except_s = (bus.mem_excepttype != 32'd0);
    if (bus.mem_excepttype == ERET_TYPE) begin
      exc_pc_s = bus.mem_cp0_epc;
    end else begin
      exc_pc_s = EXC_VECTOR;
    end
  end

  // Divider FSM: next state, start request, stall and abort
  always_comb begin
    state_d      = state_q;
    mdu_start_d  = 1'b0;
    mdu_stall_s  = 1'b0;
    mdu_cancel_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.ex_mdu_op && !flush_except_s) begin
          state_d     = S_RUN;
          mdu_start_d = 1'b1;
          mdu_stall_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        mdu_stall_s = !bus.mdu_ready;
        if (flush_except_s) begin
          state_d      = S_IDLE;
          mdu_cancel_s = 1'b1;
        end else if (bus.mdu_ready) begin
          // Result is in; hold it in DONE while MEM keeps EX frozen
          if (bus.stallreq_from_mem) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (flush_except_s || !bus.stallreq_from_mem) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pending redirect capture and load-use stall counter
  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    cnt_d     = cnt_q;
    if (flush_except_s) begin
      // Latest exception always wins the saved target
      pend_pc_d = exc_pc_s;
      if (bus.stallreq_from_if) begin
        pend_d = 1'b1;
      end else begin
        pend_d = pend_q;
      end
    end else if (!bus.stallreq_from_if) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    if (lwstall_s && !flush_except_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Stage stall/flush and redirect mux
  always_comb begin
    ex_stall_s       = mdu_stall_s || bus.stallreq_from_mem;
    ifid_stall_s     = lwstall_s || ex_stall_s || bus.stallreq_from_if;
    ex_flush_s       = flush_except_s || (lwstall_s && !ex_stall_s);
    wb_flush_s       = flush_except_s || bus.stallreq_from_mem;
    redirect_valid_s = flush_except_s || pend_q;
    // With no redirect pending, show the live target (the vector when idle)
    if (pend_q && !flush_except_s) begin
      redirect_pc_s = pend_pc_q;
    end else begin
      redirect_pc_s = exc_pc_s;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      mdu_start_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_pc_q   <= 32'd0;
      cnt_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mdu_start_q <= mdu_start_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.if_stall       = ifid_stall_s;
  assign bus.id_stall       = ifid_stall_s;
  assign bus.ex_stall       = ex_stall_s;
  assign bus.mem_stall      = bus.stallreq_from_mem;
  assign bus.if_flush       = flush_except_s;
  assign bus.id_flush       = flush_except_s;
  assign bus.ex_flush       = ex_flush_s;
  assign bus.mem_flush      = flush_except_s;
  assign bus.wb_flush       = wb_flush_s;
  assign bus.mdu_start      = mdu_start_q;
  assign bus.mdu_cancel     = mdu_cancel_s;
  assign bus.redirect_valid = redirect_valid_s;
  assign bus.redirect_pc    = redirect_pc_s;
  assign bus.lu_stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench: two controllers (load-use depth 1 with a 16-bit
// counter, depth 2 with a 4-bit counter) share one stimulus stream and are
// checked every cycle against a behavioural model, plus directed scenarios.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic [4:0]  id_rs, id_rt, ex_wreg, mem_wreg;
  logic        id_uses_rs, id_uses_rt, ex_rmem, mem_rmem;
  logic        ex_mdu_op, mdu_ready, ifreq, memreq;
  logic [31:0] exc_type, epc;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl_if #(.CNT_W(16)) b1 ();
  hazard_ctrl_if #(.CNT_W(4))  b2 ();

  assign b1.id_rs = id_rs;           assign b2.id_rs = id_rs;
  assign b1.id_rt = id_rt;           assign b2.id_rt = id_rt;
  assign b1.id_uses_rs = id_uses_rs; assign b2.id_uses_rs = id_uses_rs;
  assign b1.id_uses_rt = id_uses_rt; assign b2.id_uses_rt = id_uses_rt;
  assign b1.ex_rmem = ex_rmem;       assign b2.ex_rmem = ex_rmem;
  assign b1.ex_wreg = ex_wreg;       assign b2.ex_wreg = ex_wreg;
  assign b1.mem_rmem = mem_rmem;     assign b2.mem_rmem = mem_rmem;
  assign b1.mem_wreg = mem_wreg;     assign b2.mem_wreg = mem_wreg;
  assign b1.ex_mdu_op = ex_mdu_op;   assign b2.ex_mdu_op = ex_mdu_op;
  assign b1.mdu_ready = mdu_ready;   assign b2.mdu_ready = mdu_ready;
  assign b1.stallreq_from_if = ifreq;   assign b2.stallreq_from_if = ifreq;
  assign b1.stallreq_from_mem = memreq; assign b2.stallreq_from_mem = memreq;
  assign b1.mem_excepttype = exc_type;  assign b2.mem_excepttype = exc_type;
  assign b1.mem_cp0_epc = epc;          assign b2.mem_cp0_epc = epc;

  hazard_ctrl #(.LOAD_USE_DEPTH(1), .CNT_W(16)) u1 (.clk(clk), .resetn(resetn), .bus(b1));
  hazard_ctrl #(.LOAD_USE_DEPTH(2), .CNT_W(4))  u2 (.clk(clk), .resetn(resetn), .bus(b2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_div_busy;    // divide issued, waiting for its result
  bit          m_div_held;    // result arrived but MEM still frozen
  bit          m_start;       // start pulse due this cycle
  bit          m_pend;
  logic [31:0] m_pend_pc;
  int          m_cnt1, m_cnt2;

  function automatic bit uses(input logic [4:0] r);
    return (r != 5'd0) && ((id_uses_rs && r == id_rs) || (id_uses_rt && r == id_rt));
  endfunction

  always @(negedge clk) begin : compare_p
    bit flush, lw1, lw2, free, mstall, st1, st2, exs;
    logic [31:0] target, rpc;
    logic [11:0] e1, e2;
    if (!resetn) begin
      m_div_busy = 0; m_div_held = 0; m_start = 0;
      m_pend = 0; m_pend_pc = 32'd0; m_cnt1 = 0; m_cnt2 = 0;
    end
    flush  = (exc_type != 32'd0);
    target = (exc_type == 32'h0000000E) ? epc : 32'hBFC00380;
    lw1    = ex_rmem && uses(ex_wreg);
    lw2    = lw1 || (mem_rmem && uses(mem_wreg));
    free   = !m_div_busy && !m_div_held;
    mstall = (free && ex_mdu_op && !flush) || (m_div_busy && !mdu_ready);
    exs    = mstall || memreq;
    st1    = lw1 || exs || ifreq;
    st2    = lw2 || exs || ifreq;
    rpc    = (m_pend && !flush) ? m_pend_pc : target;
    e1 = {st1, st1, exs, memreq, flush, flush, flush || (lw1 && !exs), flush,
          flush || memreq, m_start, m_div_busy && flush, flush || m_pend};
    e2 = {st2, st2, exs, memreq, flush, flush, flush || (lw2 && !exs), flush,
          flush || memreq, m_start, m_div_busy && flush, flush || m_pend};
    chk("u1 ctl", {20'd0, b1.if_stall, b1.id_stall, b1.ex_stall, b1.mem_stall, b1.if_flush,
        b1.id_flush, b1.ex_flush, b1.mem_flush, b1.wb_flush, b1.mdu_start, b1.mdu_cancel,
        b1.redirect_valid}, {20'd0, e1});
    chk("u2 ctl", {20'd0, b2.if_stall, b2.id_stall, b2.ex_stall, b2.mem_stall, b2.if_flush,
        b2.id_flush, b2.ex_flush, b2.mem_flush, b2.wb_flush, b2.mdu_start, b2.mdu_cancel,
        b2.redirect_valid}, {20'd0, e2});
    chk("u1 rpc", b1.redirect_pc, rpc);
    chk("u2 rpc", b2.redirect_pc, rpc);
    chk("u1 cnt", {16'd0, b1.lu_stall_cnt}, m_cnt1);
    chk("u2 cnt", {28'd0, b2.lu_stall_cnt}, m_cnt2);
    if (resetn) begin
      m_start = free && ex_mdu_op && !flush;
      if (flush) begin
        m_div_busy = 0; m_div_held = 0;
      end else if (free) begin
        m_div_busy = ex_mdu_op;
      end else if (m_div_busy) begin
        if (mdu_ready) begin m_div_busy = 0; m_div_held = memreq; end
      end else begin
        m_div_held = memreq;
      end
      if (flush) m_pend_pc = target;
      if (flush && ifreq) m_pend = 1;
      else if (!flush && !ifreq) m_pend = 0;
      if (lw1 && !flush && m_cnt1 < 65535) m_cnt1++;
      if (lw2 && !flush && m_cnt2 < 15) m_cnt2++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_rmem = 1'b0; ex_wreg = 5'd0; mem_rmem = 1'b0; mem_wreg = 5'd0;
    ex_mdu_op = 1'b0; mdu_ready = 1'b0; ifreq = 1'b0; memreq = 1'b0;
    exc_type = 32'd0; epc = 32'd0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst if_stall", {31'd0, b1.if_stall}, 32'd0);
    chk("rst rpc", b1.redirect_pc, 32'hBFC00380);
    chk("rst cnt", {16'd0, b1.lu_stall_cnt}, 32'd0);
    nxt(); resetn = 1'b1;

    // Load-use from EX
    nxt(); ex_rmem = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    @(negedge clk);
    chk("lu if_stall", {31'd0, b1.if_stall}, 32'd1);
    chk("lu ex_flush", {31'd0, b1.ex_flush}, 32'd1);
    chk("lu ex_stall", {31'd0, b1.ex_stall}, 32'd0);
    nxt(); ex_rmem = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
    @(negedge clk);
    chk("lu nouse", {31'd0, b1.if_stall}, 32'd0);
    chk("lu cnt1", {16'd0, b1.lu_stall_cnt}, 32'd1);
    nxt(); ex_rmem = 1'b1; ex_wreg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    @(negedge clk);
    chk("lu r0", {31'd0, b1.if_stall}, 32'd0);

    // Load in MEM only matters at depth 2
    nxt(); mem_rmem = 1'b1; mem_wreg = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    @(negedge clk);
    chk("mem lu d2", {31'd0, b2.if_stall}, 32'd1);
    chk("mem lu d1", {31'd0, b1.if_stall}, 32'd0);

    // Divide, ready 10 cycles after start
    for (int c = 1; c <= 13; c++) begin
      nxt(); ex_mdu_op = (c <= 12); mdu_ready = (c == 12);
      @(negedge clk);
      chk($sformatf("div start c%0d", c), {31'd0, b1.mdu_start}, {31'd0, c == 2});
      chk($sformatf("div stall c%0d", c), {31'd0, b1.ex_stall}, {31'd0, c <= 11});
    end

    // Divide whose result is held by a MEM stall
    for (int c = 1; c <= 16; c++) begin
      nxt(); ex_mdu_op = (c <= 15); mdu_ready = (c == 12); memreq = (c >= 12 && c <= 14);
      @(negedge clk);
      chk($sformatf("done start c%0d", c), {31'd0, b1.mdu_start}, {31'd0, c == 2});
      chk($sformatf("done stall c%0d", c), {31'd0, b1.ex_stall}, {31'd0, c <= 14});
    end

    // ERET while fetch is busy
    for (int c = 1; c <= 4; c++) begin
      nxt(); ifreq = (c <= 2); epc = 32'h80001234;
      if (c == 1) exc_type = 32'h0000000E;
      @(negedge clk);
      chk($sformatf("eret rv c%0d", c), {31'd0, b1.redirect_valid}, {31'd0, c <= 3});
      if (c <= 3) chk($sformatf("eret pc c%0d", c), b1.redirect_pc, 32'h80001234);
      chk($sformatf("eret flush c%0d", c), {31'd0, b1.wb_flush}, {31'd0, c == 1});
    end
    nxt(); exc_type = 32'h00000008; epc = 32'h80001234;
    @(negedge clk);
    chk("exc vec pc", b1.redirect_pc, 32'hBFC00380);
    chk("exc vec rv", {31'd0, b1.redirect_valid}, 32'd1);
    nxt();
    @(negedge clk);
    chk("exc vec rv end", {31'd0, b1.redirect_valid}, 32'd0);

    // Exception in RUN
    nxt(); ex_mdu_op = 1'b1;
    nxt(); ex_mdu_op = 1'b1; exc_type = 32'h00000008;
    @(negedge clk);
    chk("cancel pulse", {31'd0, b1.mdu_cancel}, 32'd1);
    nxt();
    @(negedge clk);
    chk("cancel gone", {31'd0, b1.mdu_cancel}, 32'd0);
    chk("cancel idle", {31'd0, b1.ex_stall}, 32'd0);

    // Exception as the divide enters EX
    nxt(); ex_mdu_op = 1'b1; exc_type = 32'h00000008;
    @(negedge clk);
    chk("exc entry stall", {31'd0, b1.ex_stall}, 32'd0);
    nxt();
    @(negedge clk);
    chk("exc entry start", {31'd0, b1.mdu_start}, 32'd0);

    // Reset in RUN
    nxt(); ex_mdu_op = 1'b1;
    nxt(); ex_mdu_op = 1'b1;
    @(negedge clk);
    chk("rstrun start", {31'd0, b1.mdu_start}, 32'd1);
    nxt(); resetn = 1'b0; ex_mdu_op = 1'b1; exc_type = 32'h00000008;
    #1;
    chk("rstrun cancel", {31'd0, b1.mdu_cancel}, 32'd0);
    chk("rstrun start0", {31'd0, b1.mdu_start}, 32'd0);
    nxt(); resetn = 1'b1;
    @(negedge clk);
    chk("rstrun cnt", {16'd0, b1.lu_stall_cnt}, 32'd0);

    // Counter saturation on the narrow counter
    for (int c = 0; c < 20; c++) begin
      nxt(); ex_rmem = 1'b1; ex_wreg = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    end
    nxt();
    @(negedge clk);
    chk("sat u1", {16'd0, b1.lu_stall_cnt}, 32'd20);
    chk("sat u2", {28'd0, b2.lu_stall_cnt}, 32'd15);

    // Randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      nxt();
      resetn     = ($urandom_range(0, 199) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_rmem    = ($urandom_range(0, 2) == 0);
      ex_wreg    = 5'($urandom_range(0, 3));
      mem_rmem   = ($urandom_range(0, 2) == 0);
      mem_wreg   = 5'($urandom_range(0, 3));
      ex_mdu_op  = ($urandom_range(0, 2) == 0);
      mdu_ready  = ($urandom_range(0, 3) == 0);
      ifreq      = ($urandom_range(0, 3) == 0);
      memreq     = ($urandom_range(0, 4) == 0);
      epc        = $urandom;
      r = int'($urandom_range(0, 15));
      if (r == 0) exc_type = 32'h0000000E;
      else if (r == 1) exc_type = 32'h00000008;
      else if (r == 2) exc_type = $urandom | 32'h00000001;
      else exc_type = 32'd0;
    end
    nxt(); resetn = 1'b1;
    @(negedge clk);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
